mult_result_formatter: RTL and testbench

MULT_RESULT_FORMATTER -- requirements
Module: mult_result_formatter

---
 rtl/mult_fmt_pkg.sv | 33 +++
 rtl/mult_fmt_classify.sv | 30 +++
 rtl/mult_result_formatter.sv | 121 ++++++++++++
 tb/tb_mult_result_formatter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mult_fmt_pkg.sv
// Shared definitions for the multiplier result formatter: float field widths
// derived from the total width, exponent bias, all-ones exponent and the
// result class enum.
package mult_fmt_pkg;

    // Result class, in decreasing priority
    typedef enum logic [1:0] {ZERO, OVF, UNF, NORM} fmt_class_e;

    localparam int BIAS_SP    = 127;
    localparam int BIAS_DP    = 1023;
    localparam int EXP_INF_SP = 255;
    localparam int EXP_INF_DP = 2047;

    // Exponent field width: 8 for single, 11 for double
    function automatic int exp_width(input int w);
        return (w == 64) ? 11 : 8;
    endfunction

    // Fraction field width: 23 for single, 52 for double
    function automatic int frac_width(input int w);
        return (w == 64) ? 52 : 23;
    endfunction

    function automatic int bias_of(input int w);
        return (w == 64) ? BIAS_DP : BIAS_SP;
    endfunction

    // All-ones biased exponent (Inf/NaN encoding) for an EW-bit field
    function automatic int exp_inf(input int ew);
        return (1 << ew) - 1;
    endfunction

endpackage

// File: rtl/mult_fmt_classify.sv
// Combinational classification of a product packet into ZERO/OVF/UNF/NORM.
// exp_in is a two's-complement biased exponent two bits wider than the field.
module mult_fmt_classify
    import mult_fmt_pkg::*;
#(
    parameter int EW = 8
) (
    input  logic [EW+1:0] exp_in,
    input  logic          zero_m_flag,
    output fmt_class_e    cls
);

    localparam logic [EW+1:0] INF_EXP = (EW+2)'(exp_inf(EW));

    logic exp_ovf;
    logic exp_unf;

    assign exp_ovf = $signed(exp_in) >= $signed(INF_EXP);
    // Negative or exactly zero; denormals are flushed, never produced
    assign exp_unf = exp_in[EW+1] || (exp_in == '0);

    // Priority: zero operand beats any exponent condition
    always_comb begin
        cls = NORM;
        if (zero_m_flag)  cls = ZERO;
        else if (exp_ovf) cls = OVF;
        else if (exp_unf) cls = UNF;
    end

endmodule

// File: rtl/mult_result_formatter.sv
// Two-stage valid/ready formatter packing a normalised product into IEEE-754.
// S1 registers the packet plus its class, S2 registers the packed result and
// flags. W selects single (32) or double (64) precision; other widths are not
// supported.
// Optional: define MULT_STICKY_FLAGS_EN to accumulate sticky overflow and
// underflow flags; otherwise the sticky ports are tied to 0.
module mult_result_formatter
    import mult_fmt_pkg::*;
#(
    parameter  int W  = 32,
    localparam int EW = exp_width(W),
    localparam int SW = frac_width(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          sign_in,
    input  logic [EW+1:0] exp_in,
    input  logic [SW-1:0] mant_in,
    input  logic          zero_m_flag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  result,
    output logic          zero_flag,
    output logic          ovf_flag,
    output logic          unf_flag,
    input  logic          clr_sticky,
    output logic          sticky_ovf,
    output logic          sticky_unf
);

    logic          ready_en;
    logic          s1_valid;
    logic          s1_sign;
    logic [EW-1:0] s1_exp;
    logic [SW-1:0] s1_mant;
    fmt_class_e    s1_cls;
    fmt_class_e    cls_c;
    logic          s2_adv;

    mult_fmt_classify #(.EW(EW)) u_classify (
        .exp_in      (exp_in),
        .zero_m_flag (zero_m_flag),
        .cls         (cls_c)
    );

    // S2 (the output register) is free when empty or being drained
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = ready_en && (!s1_valid || s2_adv);

    // Hold in_ready low in reset and until the first clock after release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ready_en <= 1'b0;
        else      ready_en <= 1'b1;
    end

    // S1: capture the packet and its class whenever the stage can move
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_mant  <= '0;
            s1_cls   <= ZERO;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= sign_in;
                s1_exp  <= exp_in[EW-1:0];
                s1_mant <= mant_in;
                s1_cls  <= cls_c;
            end
        end
    end

    // S2: pack the result by class; held while the consumer stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero_flag <= 1'b0;
            ovf_flag  <= 1'b0;
            unf_flag  <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                zero_flag <= (s1_cls == ZERO);
                ovf_flag  <= (s1_cls == OVF);
                unf_flag  <= (s1_cls == UNF);
                case (s1_cls)
                    OVF:     result <= {s1_sign, {EW{1'b1}}, {SW{1'b0}}};
                    NORM:    result <= {s1_sign, s1_exp, s1_mant};
                    default: result <= {s1_sign, {(W-1){1'b0}}};
                endcase
            end
        end
    end

`ifdef MULT_STICKY_FLAGS_EN
    // Sticky flags accumulate on each handshake; a clear wins over a set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_ovf <= 1'b0;
            sticky_unf <= 1'b0;
        end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
            sticky_unf <= 1'b0;
        end else if (out_valid && out_ready) begin
            sticky_ovf <= sticky_ovf | ovf_flag;
            sticky_unf <= sticky_unf | unf_flag;
        end
    end
`else
    logic unused_clr_sticky;
    assign unused_clr_sticky = clr_sticky;
    assign sticky_ovf = 1'b0;
    assign sticky_unf = 1'b0;
`endif

endmodule

// File: tb/tb_mult_result_formatter.sv
// Directed bench for mult_result_formatter (W=32): single packets per class,
// field boundaries, backpressure ordering and reset with both stages full.
module tb_mult_result_formatter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sign_in = 1'b0;
    logic [9:0]  exp_in = '0;
    logic [22:0] mant_in = '0;
    logic        zero_m_flag = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero_flag, ovf_flag, unf_flag;
    logic        clr_sticky = 1'b0;
    logic        sticky_ovf, sticky_unf;

    int checks = 0;
    int failures = 0;

`ifdef MULT_STICKY_FLAGS_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    mult_result_formatter #(.W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sign_in     (sign_in),
        .exp_in      (exp_in),
        .mant_in     (mant_in),
        .zero_m_flag (zero_m_flag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero_flag   (zero_flag),
        .ovf_flag    (ovf_flag),
        .unf_flag    (unf_flag),
        .clr_sticky  (clr_sticky),
        .sticky_ovf  (sticky_ovf),
        .sticky_unf  (sticky_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One packet through an idle pipe; ef = {zero, ovf, unf}
    task automatic run1(input logic s, input logic [9:0] e, input logic [22:0] m,
                        input logic z, input logic [31:0] er, input logic [2:0] ef,
                        input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        sign_in = s; exp_in = e; mant_in = m; zero_m_flag = z; in_valid = 1'b1;
        #1 chk({tag, "_rdy"}, 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 64'(out_valid), 64'(0));
        @(negedge clk);
        chk({tag, "_vld"}, 64'(out_valid), 64'(1));
        chk({tag, "_res"}, 64'(result), 64'(er));
        chk({tag, "_flg"}, 64'({zero_flag, ovf_flag, unf_flag}), 64'(ef));
    endtask

    logic [31:0] exp_q [4];
    int nacc, ngot;
    logic stale;

    initial begin
        // Reset state
        #1;
        chk("rst_rdy", 64'(in_ready), 64'(0));
        chk("rst_vld", 64'(out_valid), 64'(0));
        chk("rst_res", 64'(result), 64'(0));
        chk("rst_stk", 64'({sticky_ovf, sticky_unf}), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_rdy", 64'(in_ready), 64'(1));

        // Class coverage
        run1(1'b0, 10'd127, 23'h0, 1'b0, 32'h3F800000, 3'b000, "norm");
        run1(1'b1, 10'd300, 23'h0, 1'b1, 32'h80000000, 3'b100, "zero");
        run1(1'b0, 10'd255, 23'h0, 1'b0, 32'h7F800000, 3'b010, "ovf");
        run1(1'b0, 10'h3FB, 23'h1, 1'b0, 32'h00000000, 3'b001, "unf");
        @(negedge clk);
        chk("stk_ovf", 64'(sticky_ovf), 64'(STK));
        chk("stk_unf", 64'(sticky_unf), 64'(STK));
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        chk("stk_clr", 64'({sticky_ovf, sticky_unf}), 64'(0));

        // Field boundaries
        run1(1'b0, 10'd254, 23'h7FFFFF, 1'b0, 32'h7F7FFFFF, 3'b000, "maxn");
        run1(1'b1, 10'd1,   23'h0,      1'b0, 32'h80800000, 3'b000, "minn");
        run1(1'b1, 10'd0,   23'h12345,  1'b0, 32'h80000000, 3'b001, "exp0");
        run1(1'b0, 10'h1FF, 23'h0,      1'b0, 32'h7F800000, 3'b010, "big");
        run1(1'b0, 10'h200, 23'h0,      1'b0, 32'h00000000, 3'b001, "mostneg");
        run1(1'b1, 10'd256, 23'h55,     1'b0, 32'hFF800000, 3'b010, "negovf");

        // Backpressure: 4 packets, out_ready low for the first 3 cycles
        for (int i = 0; i < 4; i++)
            exp_q[i] = {i[0], 8'(i + 1), 23'(32'h100 + i)};
        nacc = 0;
        ngot = 0;
        for (int cyc = 0; cyc < 30 && ngot < 4; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 3);
            if (nacc < 4) begin
                sign_in = exp_q[nacc][31];
                exp_in = {2'b00, exp_q[nacc][30:23]};
                mant_in = exp_q[nacc][22:0];
                zero_m_flag = 1'b0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc == 2) begin
                chk("bp_rdy_low", 64'(in_ready), 64'(0));
                chk("bp_nacc", 64'(nacc), 64'(2));
                chk("bp_hold0", 64'(result), 64'(exp_q[0]));
            end
            if (cyc == 3) chk("bp_hold1", 64'(result), 64'(exp_q[0]));
            if (out_valid && out_ready) begin
                chk($sformatf("bp_out%0d", ngot), 64'(result), 64'(exp_q[ngot]));
                ngot++;
            end
            if (in_valid && in_ready) nacc++;
        end
        in_valid = 1'b0;
        chk("bp_count", 64'(ngot), 64'(4));

        // Reset with both stages full
        @(negedge clk);
        out_ready = 1'b0;
        sign_in = 1'b0; exp_in = 10'd5; mant_in = 23'h1; in_valid = 1'b1;
        @(negedge clk);
        exp_in = 10'd6;
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("mid_full", 64'(out_valid), 64'(1));
        rst = 1'b0;
        #1;
        chk("mid_vld", 64'(out_valid), 64'(0));
        chk("mid_res", 64'(result), 64'(0));
        chk("mid_rdy", 64'(in_ready), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        stale = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        chk("mid_stale", 64'(stale), 64'(0));
        chk("mid_rdy1", 64'(in_ready), 64'(1));
        run1(1'b0, 10'd128, 23'h400000, 1'b0, 32'h40400000, 3'b000, "post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
